pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 34 +++
 rtl/pc_sequencer_wait_timer.sv | 31 +++
 rtl/pc_sequencer.sv | 149 ++++++++++++++
 tb/tb_pc_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions: data width, PC sequencer state encoding and the
// bundle of decoded control outputs.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    F_ADDR = 3'd1,
    F_WAIT = 3'd2,
    F_INC  = 3'd3,
    J_LO   = 3'd4,
    J_HI   = 3'd5,
    S_LO   = 3'd6,
    S_HI   = 3'd7
  } pc_state_e;

  typedef struct packed {
    logic pc_cs;
    logic pc_oe_a;
    logic pc_cnt_en;
    logic pc_we_l;
    logic pc_we_h;
    logic pc_oe_l;
    logic pc_oe_h;
    logic mem_rd;
    logic fetch_done;
    logic jump_done;
    logic save_done;
  } pc_ctrl_t;

endpackage

// File: rtl/pc_sequencer_wait_timer.sv
// Wait counter for the fetch handshake: cleared by load, counts on enable,
// flags terminal count at TIMEOUT-1.
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: arbitrates fetch / jump / save requests and drives the strobes
// of an external PC register and the memory read.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int TIMEOUT    = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic fetch_req,
  input  logic jump_req,
  input  logic save_req,
  input  logic mem_ready,
  input  logic pc_carry,
  output logic pc_cs,
  output logic pc_oe_a,
  output logic pc_cnt_en,
  output logic pc_we_l,
  output logic pc_we_h,
  output logic pc_oe_l,
  output logic pc_oe_h,
  output logic mem_rd,
  output logic busy,
  output logic fetch_done,
  output logic jump_done,
  output logic save_done,
  output logic timeout_err,
  output logic wrap
);

  if (TIMEOUT < 1 || TIMEOUT > 255 || DATA_WIDTH < 1) begin : g_bad_param
    $error("pc_sequencer: TIMEOUT must be 1..255 and DATA_WIDTH positive");
  end

  pc_state_e state, state_next;
  pc_ctrl_t  ctrl;
  logic      wait_tc;
  logic      accept;
  logic      timeout_hit;

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk  (clk),
    .reset(reset),
    .load (state == F_ADDR),
    .en   (state == F_WAIT && !mem_ready),
    .tc   (wait_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: combinational blocks assign a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (jump_req)       state_next = J_LO;
        else if (save_req)  state_next = S_LO;
        else if (fetch_req) state_next = F_ADDR;
      end
      F_ADDR: state_next = F_WAIT;
      F_WAIT: begin
        if (mem_ready)    state_next = F_INC;
        else if (wait_tc) state_next = IDLE;
      end
      F_INC:   state_next = IDLE;
      J_LO:    state_next = J_HI;
      J_HI:    state_next = IDLE;
      S_LO:    state_next = S_HI;
      S_HI:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every strobe is a pure decode of the state, so only one register-side
  // driver can be active at a time.
  always_comb begin
    ctrl = '0;
    case (state)
      F_ADDR, F_WAIT: begin
        ctrl.pc_cs   = 1'b1;
        ctrl.pc_oe_a = 1'b1;
        ctrl.mem_rd  = 1'b1;
      end
      F_INC: begin
        ctrl.pc_cs      = 1'b1;
        ctrl.pc_cnt_en  = 1'b1;
        ctrl.fetch_done = 1'b1;
      end
      J_LO: begin
        ctrl.pc_cs   = 1'b1;
        ctrl.pc_we_l = 1'b1;
      end
      J_HI: begin
        ctrl.pc_cs     = 1'b1;
        ctrl.pc_we_h   = 1'b1;
        ctrl.jump_done = 1'b1;
      end
      S_LO: begin
        ctrl.pc_cs   = 1'b1;
        ctrl.pc_oe_l = 1'b1;
      end
      S_HI: begin
        ctrl.pc_cs     = 1'b1;
        ctrl.pc_oe_h   = 1'b1;
        ctrl.save_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign accept      = (state == IDLE) && (jump_req || save_req || fetch_req);
  assign timeout_hit = (state == F_WAIT) && !mem_ready && wait_tc;

  // wrap is only cleared by reset; timeout_err clears when the next request is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_err <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      if (accept)           timeout_err <= 1'b0;
      else if (timeout_hit) timeout_err <= 1'b1;
      if (state == F_INC && pc_carry) wrap <= 1'b1;
    end
  end

  assign pc_cs      = ctrl.pc_cs;
  assign pc_oe_a    = ctrl.pc_oe_a;
  assign pc_cnt_en  = ctrl.pc_cnt_en;
  assign pc_we_l    = ctrl.pc_we_l;
  assign pc_we_h    = ctrl.pc_we_h;
  assign pc_oe_l    = ctrl.pc_oe_l;
  assign pc_oe_h    = ctrl.pc_oe_h;
  assign mem_rd     = ctrl.mem_rd;
  assign fetch_done = ctrl.fetch_done;
  assign jump_done  = ctrl.jump_done;
  assign save_done  = ctrl.save_done;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer with a behavioural 16-bit PC register
// model on an 8-bit data bus.
module tb_pc_sequencer;

  localparam int DW      = 8;
  localparam int TIMEOUT = 5;

  // Expected control patterns: {busy,cs,oe_a,mem_rd,cnt_en,we_l,we_h,oe_l,oe_h,fetch_done,jump_done,save_done}
  localparam logic [11:0] O_IDLE = 12'b0000_0000_0000;
  localparam logic [11:0] O_FA   = 12'b1111_0000_0000;
  localparam logic [11:0] O_FI   = 12'b1100_1000_0100;
  localparam logic [11:0] O_JL   = 12'b1100_0100_0000;
  localparam logic [11:0] O_JH   = 12'b1100_0010_0010;
  localparam logic [11:0] O_SL   = 12'b1100_0001_0000;
  localparam logic [11:0] O_SH   = 12'b1100_0000_1001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic fetch_req = 1'b0, jump_req = 1'b0, save_req = 1'b0, mem_ready = 1'b0;
  logic pc_carry;
  logic pc_cs, pc_oe_a, pc_cnt_en, pc_we_l, pc_we_h, pc_oe_l, pc_oe_h, mem_rd;
  logic busy, fetch_done, jump_done, save_done, timeout_err, wrap;

  logic [DW-1:0]   bus_drv = '0;
  logic [DW-1:0]   bus_rd;
  logic [2*DW-1:0] pc = '0;

  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .jump_req   (jump_req),
    .save_req   (save_req),
    .mem_ready  (mem_ready),
    .pc_carry   (pc_carry),
    .pc_cs      (pc_cs),
    .pc_oe_a    (pc_oe_a),
    .pc_cnt_en  (pc_cnt_en),
    .pc_we_l    (pc_we_l),
    .pc_we_h    (pc_we_h),
    .pc_oe_l    (pc_oe_l),
    .pc_oe_h    (pc_oe_h),
    .mem_rd     (mem_rd),
    .busy       (busy),
    .fetch_done (fetch_done),
    .jump_done  (jump_done),
    .save_done  (save_done),
    .timeout_err(timeout_err),
    .wrap       (wrap)
  );

  // PC register model driven by the sequencer strobes.
  always @(posedge clk) begin
    if (pc_we_l)   pc[DW-1:0]    <= bus_drv;
    if (pc_we_h)   pc[2*DW-1:DW] <= bus_drv;
    if (pc_cnt_en) pc            <= pc + 1'b1;
  end
  assign pc_carry = &pc;
  assign bus_rd   = pc_oe_l ? pc[DW-1:0] : (pc_oe_h ? pc[2*DW-1:DW] : '0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] ctrl_now();
    return {busy, pc_cs, pc_oe_a, mem_rd, pc_cnt_en, pc_we_l, pc_we_h,
            pc_oe_l, pc_oe_h, fetch_done, jump_done, save_done};
  endfunction

  // Strobe exclusivity on every cycle out of reset.
  always @(negedge clk) begin
    if (mon_en && reset === 1'b1) begin
      check("excl_we_oe", 32'($countones({pc_we_l, pc_we_h, pc_oe_l, pc_oe_h, pc_oe_a}) <= 1), 1);
      check("excl_cnt", {31'b0, pc_cnt_en & (pc_we_l | pc_we_h | pc_oe_l | pc_oe_h | pc_oe_a)}, 0);
    end
  end

  // Called at a negedge; returns at the first negedge with busy low.
  task automatic wait_idle(input string tag, output int cycles, output bit fd_seen);
    cycles  = 0;
    fd_seen = 0;
    while (busy && cycles < 100) begin
      if (fetch_done) fd_seen = 1;
      @(negedge clk);
      cycles++;
    end
    check({tag, "_idle_bound"}, {31'b0, busy}, 0);
  endtask

  task automatic run_fetch(input string tag);
    int cyc;
    bit fd;
    @(negedge clk); fetch_req = 1; mem_ready = 1;
    @(negedge clk); fetch_req = 0;
    wait_idle(tag, cyc, fd);
    mem_ready = 0;
    check({tag, "_done"}, {31'b0, fd}, 1);
    check({tag, "_cycles"}, cyc, 3);
  endtask

  task automatic run_jump(input string tag, input logic [7:0] lo, input logic [7:0] hi);
    @(negedge clk); jump_req = 1;
    @(negedge clk); jump_req = 0; bus_drv = lo;
    @(negedge clk); bus_drv = hi;
    check({tag, "_jhi"}, ctrl_now(), O_JH);
    @(negedge clk); bus_drv = '0;
  endtask

  task automatic run_timeout(input string tag, output int cyc, output bit fd);
    @(negedge clk); fetch_req = 1; mem_ready = 0;
    @(negedge clk); fetch_req = 0;
    wait_idle(tag, cyc, fd);
  endtask

  // Called at a negedge; asserts reset mid-cycle and releases it at the next negedge.
  task automatic pulse_reset(input string tag);
    #2 reset = 0;
    #1 check({tag, "_async"}, {ctrl_now(), timeout_err, wrap}, 0);
    @(negedge clk);
    check({tag, "_held"}, {ctrl_now(), timeout_err, wrap}, 0);
    reset = 1;
  endtask

  typedef struct {
    logic        jump;
    logic        save;
    logic        fetch;
    logic        ready;
    logic [7:0]  bus;
    logic [11:0] exp_ctrl;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  fd;
    logic [15:0] pc_before;

    repeat (3) @(negedge clk);
    check("reset_state", {ctrl_now(), timeout_err, wrap}, 0);
    reset   = 1;
    mon_en  = 1;

    // Cycle-by-cycle: fetch with ready on 2nd F_WAIT, jump 0x1234, save, idle.
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, O_IDLE};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, O_FA};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, O_FA};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, O_FA};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, O_FI};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, O_IDLE};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h34, O_JL};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h12, O_JH};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, O_IDLE};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, O_SL};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, O_SH};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, O_IDLE};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, O_IDLE};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      jump_req  = vecs[i].jump;
      save_req  = vecs[i].save;
      fetch_req = vecs[i].fetch;
      mem_ready = vecs[i].ready;
      bus_drv   = vecs[i].bus;
      check($sformatf("vec%0d_ctrl", i), ctrl_now(), vecs[i].exp_ctrl);
      check($sformatf("vec%0d_flags", i), {timeout_err, wrap}, 0);
      if (i == 4) check("vec_pc_before_inc", pc, 16'h0000);
      if (i == 5) check("vec_pc_after_fetch", pc, 16'h0001);
    end
    @(negedge clk);
    mem_ready = 0;
    check("vec_pc_after_jump", pc, 16'h1234);

    // All three requests: jump, then save, then fetch, one IDLE cycle apart.
    begin
      logic [11:0] exp_seq [11];
      exp_seq = '{O_IDLE, O_JL, O_JH, O_IDLE, O_SL, O_SH, O_IDLE, O_FA, O_FA, O_FI, O_IDLE};
      for (int i = 0; i < 11; i++) begin
        if (i > 0) @(negedge clk);
        jump_req  = (i == 0);
        save_req  = (i <= 3);
        fetch_req = (i <= 6);
        mem_ready = 1;
        bus_drv   = (i == 1) ? 8'h34 : ((i == 2) ? 8'h12 : 8'h00);
        check($sformatf("prio%0d_ctrl", i), ctrl_now(), exp_seq[i]);
        if (i == 4) check("prio_save_lo_bus", bus_rd, 8'h34);
        if (i == 5) check("prio_save_hi_bus", bus_rd, 8'h12);
      end
      mem_ready = 0;
      check("prio_pc", pc, 16'h1235);
    end

    // Wrap from 0xFFFF; wrap stays set through later fetches.
    run_jump("wrap_jump", 8'hFF, 8'hFF);
    check("wrap_pc_loaded", pc, 16'hFFFF);
    check("wrap_before", {31'b0, wrap}, 0);
    run_fetch("wrap_fetch1");
    check("wrap_pc_zero", pc, 16'h0000);
    check("wrap_set", {31'b0, wrap}, 1);
    run_fetch("wrap_fetch2");
    check("wrap_pc_one", pc, 16'h0001);
    check("wrap_sticky", {31'b0, wrap}, 1);

    // Timeout: F_ADDR plus TIMEOUT F_WAIT cycles, no increment, no done.
    pc_before = pc;
    run_timeout("to1", cyc, fd);
    check("to1_busy_cycles", cyc, TIMEOUT + 1);
    check("to1_no_done", {31'b0, fd}, 0);
    check("to1_pc_unchanged", pc, pc_before);
    check("to1_err_set", {31'b0, timeout_err}, 1);
    check("to1_wrap_kept", {31'b0, wrap}, 1);
    @(negedge clk); fetch_req = 1; mem_ready = 1;
    check("to1_err_idle", {31'b0, timeout_err}, 1);
    @(negedge clk); fetch_req = 0;
    check("to1_err_cleared", {31'b0, timeout_err}, 0);
    wait_idle("to1_refetch", cyc, fd);
    mem_ready = 0;
    check("to1_refetch_done", {31'b0, fd}, 1);
    check("to1_refetch_pc", pc, pc_before + 16'd1);

    // Reset during J_LO: outputs and wrap clear at once, PC untouched.
    pc_before = pc;
    @(negedge clk); jump_req = 1;
    @(negedge clk); jump_req = 0; bus_drv = 8'hA5;
    check("rst_jlo_state", ctrl_now(), O_JL);
    pulse_reset("rst_jlo");
    bus_drv = '0;
    @(negedge clk);
    check("rst_jlo_idle", {ctrl_now(), timeout_err, wrap}, 0);
    check("rst_jlo_pc", pc, pc_before);

    // Reset in IDLE clears a pending timeout_err.
    run_timeout("to2", cyc, fd);
    check("to2_err_set", {31'b0, timeout_err}, 1);
    pulse_reset("rst_to");

    // Reset during F_WAIT with fetch_req held: accepted on first edge after release.
    @(negedge clk); fetch_req = 1; mem_ready = 0;
    @(negedge clk); fetch_req = 0;
    @(negedge clk);
    check("rst_fw_state", ctrl_now(), O_FA);
    fetch_req = 1;
    pulse_reset("rst_fw");
    @(negedge clk);
    fetch_req = 0;
    mem_ready = 1;
    check("rst_release_accept", ctrl_now(), O_FA);
    wait_idle("rst_release_fetch", cyc, fd);
    mem_ready = 0;
    check("rst_release_done", {31'b0, fd}, 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
